// File: rtl/state_mac_three_if.sv
// Signal bundle for the six-state sequence tracker: control inputs in,
// state code and Moore/Mealy outputs back out.
interface state_mac_three_if;
  logic       i_x;
  logic       i_y;
  logic [2:0] sta;
  logic [1:0] o_z1;
  logic [1:0] o_z2;

  modport master (
    output i_x,
    output i_y,
    input  sta,
    input  o_z1,
    input  o_z2
  );

  modport slave (
    input  i_x,
    input  i_y,
    output sta,
    output o_z1,
    output o_z2
  );
endinterface

// File: rtl/state_mac_three.sv
// Six-state sequence tracker driven by X/Y, with a Moore output decoded from
// the state and a Mealy output that follows the live inputs in S3 and S5.
module state_mac_three (
  input  logic             i_clk,
  input  logic             i_rst_n,
  state_mac_three_if.slave bus
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100,
    S5 = 3'b101
  } state_e;

  state_e     state_q;
  state_e     state_d;
  logic [1:0] z1;
  logic [1:0] z2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Any code outside S0..S5 recovers to S0 on the next edge.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0: state_d = bus.i_x ? S1 : S0;
      S1: begin
        if (!bus.i_x) begin
          state_d = S2;
        end else begin
          state_d = bus.i_y ? S1 : S0;
        end
      end
      S2: begin
        if (bus.i_x) begin
          state_d = S3;
        end else begin
          state_d = bus.i_y ? S2 : S0;
        end
      end
      S3: begin
        if (!bus.i_x) begin
          state_d = S4;
        end else begin
          state_d = bus.i_y ? S3 : S5;
        end
      end
      S4: state_d = bus.i_x ? S5 : S0;
      S5: begin
        if (!bus.i_y) begin
          state_d = S0;
        end else begin
          state_d = bus.i_x ? S1 : S5;
        end
      end
      default: state_d = S0;
    endcase
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  always_comb begin
    z1 = 2'b00;
    z2 = 2'b00;
    if (i_rst_n) begin
      case (state_q)
        S1, S2: z1 = 2'b01;
        S3, S4: z1 = 2'b10;
        S5:     z1 = 2'b11;
        default: z1 = 2'b00;
      endcase
      case (state_q)
        S3:      z2 = {bus.i_y, bus.i_x};
        S5:      z2 = {bus.i_x, bus.i_y};
        default: z2 = 2'b00;
      endcase
    end
  end

  assign bus.sta  = state_q;
  assign bus.o_z1 = z1;
  assign bus.o_z2 = z2;

endmodule

// File: tb/tb_state_mac_three.sv
// Directed and free-running checks of state_mac_three against hand-computed
// values and a small reference transition table.
module tb_state_mac_three;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  state_mac_three_if bus ();

  state_mac_three dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0b exp=%0b at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive inputs away from the edge, clock once, then settle before sampling.
  task automatic applyStimulus(input logic x, input logic y);
    bus.i_x = x;
    bus.i_y = y;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [2:0] s, input logic [1:0] z1,
                            input logic [1:0] z2);
    checkOutput({tag, "_sta"}, bus.sta, s);
    checkOutput({tag, "_z1"}, {1'b0, bus.o_z1}, {1'b0, z1});
    checkOutput({tag, "_z2"}, {1'b0, bus.o_z2}, {1'b0, z2});
  endtask

  function automatic logic [2:0] modelNext(input logic [2:0] s, input logic x, input logic y);
    case (s)
      3'd0: return x ? 3'd1 : 3'd0;
      3'd1: if (!x) return 3'd2; else return y ? 3'd1 : 3'd0;
      3'd2: if (x) return 3'd3; else return y ? 3'd2 : 3'd0;
      3'd3: if (!x) return 3'd4; else return y ? 3'd3 : 3'd5;
      3'd4: return x ? 3'd5 : 3'd0;
      3'd5: if (!y) return 3'd0; else return x ? 3'd1 : 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] modelZ1(input logic [2:0] s);
    case (s)
      3'd1, 3'd2: return 2'b01;
      3'd3, 3'd4: return 2'b10;
      3'd5:       return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  initial begin
    logic [2:0] prev;
    logic       px;
    logic       py;
    total = 0;
    bad   = 0;

    // Reset held with both inputs high
    rst_n    = 1'b0;
    bus.i_x  = 1'b1;
    bus.i_y  = 1'b1;
    #5;
    checkState("rst", 3'b000, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    checkState("rst_edge", 3'b000, 2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Full walk x = 1,0,1,0,1 with y = 1
    applyStimulus(1'b1, 1'b1);
    checkState("walk_s1", 3'b001, 2'b01, 2'b00);
    applyStimulus(1'b0, 1'b1);
    checkState("walk_s2", 3'b010, 2'b01, 2'b00);
    applyStimulus(1'b1, 1'b1);
    checkState("walk_s3", 3'b011, 2'b10, 2'b11);
    bus.i_x = 1'b0;
    #1;
    checkOutput("s3_z2_x0", {1'b0, bus.o_z2}, 3'b010);
    applyStimulus(1'b0, 1'b1);
    checkState("walk_s4", 3'b100, 2'b10, 2'b00);
    applyStimulus(1'b1, 1'b1);
    checkState("walk_s5", 3'b101, 2'b11, 2'b11);

    // Hold in S5 for three edges
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkState("s5_hold", 3'b101, 2'b11, 2'b01);
    end

    // Mealy toggle without a clock edge
    bus.i_x = 1'b1;
    #2;
    checkState("s5_mealy_x1", 3'b101, 2'b11, 2'b11);
    bus.i_x = 1'b0;
    #2;
    checkState("s5_mealy_x0", 3'b101, 2'b11, 2'b01);

    // Fall-back paths
    applyStimulus(1'b0, 1'b0);
    checkState("s5_fall", 3'b000, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b1);
    checkState("s0_hold", 3'b000, 2'b00, 2'b00);
    applyStimulus(1'b1, 1'b0);
    checkState("to_s1", 3'b001, 2'b01, 2'b00);
    applyStimulus(1'b1, 1'b1);
    checkState("s1_hold", 3'b001, 2'b01, 2'b00);
    applyStimulus(1'b1, 1'b0);
    checkState("s1_fall", 3'b000, 2'b00, 2'b00);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkState("to_s2", 3'b010, 2'b01, 2'b00);
    applyStimulus(1'b0, 1'b1);
    checkState("s2_hold", 3'b010, 2'b01, 2'b00);
    applyStimulus(1'b0, 1'b0);
    checkState("s2_fall", 3'b000, 2'b00, 2'b00);

    // S3 -> S5 on x=1,y=0, then S5 -> S1 on x=1,y=1
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkState("s3_xy10", 3'b011, 2'b10, 2'b01);
    applyStimulus(1'b1, 1'b0);
    checkState("s3_to_s5", 3'b101, 2'b11, 2'b10);
    applyStimulus(1'b1, 1'b1);
    checkState("s5_to_s1", 3'b001, 2'b01, 2'b00);

    // S4 -> S0 on x=0
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkState("at_s4", 3'b100, 2'b10, 2'b00);
    applyStimulus(1'b0, 1'b0);
    checkState("s4_fall", 3'b000, 2'b00, 2'b00);

    // Async reset mid-cycle while in S3
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkState("pre_async", 3'b011, 2'b10, 2'b11);
    #4;
    rst_n = 1'b0;
    #1;
    checkState("async_rst", 3'b000, 2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running: x toggles every cycle, y every six cycles
    bus.i_x = 1'b0;
    bus.i_y = 1'b0;
    for (int i = 0; i < 100; i++) begin
      prev = bus.sta;
      px   = bus.i_x;
      py   = bus.i_y;
      @(posedge clk);
      #1;
      checkOutput("free_legal", {2'b00, (bus.sta > 3'd5)}, 3'b000);
      checkOutput("free_next", bus.sta, modelNext(prev, px, py));
      checkOutput("free_z1", {1'b0, bus.o_z1}, {1'b0, modelZ1(bus.sta)});
      bus.i_x = ~bus.i_x;
      if ((i + 1) % 6 == 0) bus.i_y = ~bus.i_y;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/state_mac_three.md
Name: state_mac_three

Overview:
- Six-state synchronous finite state machine driven by two 1-bit control inputs, i_x and i_y.
- Exposes its current state code on `sta` for debug and observation.
- Produces two 2-bit outputs:
  - o_z1 is a Moore output, decoded from the state only.
  - o_z2 is a Mealy output, decoded from the state and the live inputs.
- Used as a small sequence-tracking control block inside a lab datapath.

Parameters:
- None. State encoding is fixed as listed under Behaviour.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_x  input  1  control input X, sampled at the rising edge
- i_y  input  1  control input Y, sampled at the rising edge
- sta  output  3  current state register value
- o_z1  output  2  Moore output, function of sta only
- o_z2  output  2  Mealy output, function of sta, i_x and i_y

Behaviour:
- One clock (i_clk). Reset is asynchronous, active-low (i_rst_n).
- Reset:
  - i_rst_n=0 forces sta=S0 immediately, with no clock required.
  - While in reset, o_z1=00 and o_z2=00 regardless of the inputs.
  - Reset may assert mid-operation from any state; the FSM returns to S0 at once.
- After i_rst_n deasserts, the first rising edge evaluates transitions from S0.
- State encoding (3-bit binary): S0=000, S1=001, S2=010, S3=011, S4=100, S5=101.
  - Codes 110 and 111 are illegal.
  - From an illegal code, the next state is S0 and o_z1=o_z2=00.
- Next-state rules, evaluated on i_x/i_y sampled at the rising edge:
  - S0: x=1 -> S1; x=0 -> S0.
  - S1: x=0 -> S2; x=1,y=1 -> S1; x=1,y=0 -> S0.
  - S2: x=1 -> S3; x=0,y=1 -> S2; x=0,y=0 -> S0.
  - S3: x=0 -> S4; x=1,y=1 -> S3; x=1,y=0 -> S5.
  - S4: x=1 -> S5; x=0 -> S0.
  - S5: y=0 -> S0; y=1,x=1 -> S1; y=1,x=0 -> S5.
- Latency: sta updates one clock edge after the inputs are sampled; there is no pipeline beyond the state register.
- o_z1 (combinational decode of sta; glitch-free relative to sta):
  - S0 -> 00
  - S1 -> 01
  - S2 -> 01
  - S3 -> 10
  - S4 -> 10
  - S5 -> 11
- o_z2 (combinational; follows input changes within the same cycle):
  - S3 -> {i_y, i_x}
  - S5 -> {i_x, i_y}
  - all other states -> 00
- Input changes between clock edges affect only o_z2; sta changes only on an edge or on reset.
- No handshake. Every rising edge outside reset is a valid transition.

Test Plan:
- Reset: hold i_rst_n=0 for 5 ns with x=1,y=1 -> sta=000, o_z1=00, o_z2=00. Release reset; first edge with x=1 -> sta=001, o_z1=01.
- Full walk: from S0, apply x sequence 1,0,1,0,1 with y=1 on successive edges.
  - sta sequence: 001, 010, 011, 100, 101.
  - o_z1 sequence: 01, 01, 10, 10, 11.
  - In S3 with x=1,y=1 -> o_z2=11.
- Fall-back paths:
  - In S1 apply x=1,y=0 -> S0.
  - In S2 apply x=0,y=0 -> S0.
  - In S5 apply y=0 -> S0, o_z1=00.
- Hold and Mealy behaviour:
  - In S5, x=0,y=1 for 3 edges -> sta stays 101.
  - Toggling x mid-cycle in S5 changes o_z2 between 01 and 11 without a clock edge.
- Async reset mid-run: assert i_rst_n=0 between edges while in S3 -> sta=000 immediately, before the next edge.
- Free-running stimulus: 20 ns clock, x toggled every 20 ns, y toggled every 120 ns, 2 µs run.
  - sta never takes 110 or 111.
  - o_z1 always matches the decode of sta.
  - Every sta transition matches the next-state table.
